// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   - FSM state encoding (IDLE/FETCH/HALTED/FAULT)
//   - word / address width constants and the PC increment step
//   - default reset PC
//   - align_word(): clears the two byte-offset bits of an address
// Optional feature macro used by the top: FETCH_BOUNDS_CHECK_EN
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // Instructions are word aligned; a redirect target's low two bits are
  // dropped rather than trapped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~(ADDR_W'(3));
  endfunction

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program-counter register with its next-PC mux.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset, loads RESET_PC
//   i_inc     : advance PC by one word (pc + 4, wraps modulo 2^32)
//   i_redir   : load i_target (already word aligned by the caller)
//   i_target  : redirect address
//   o_pc      : current PC
//   o_pc4     : current PC + 4 (modulo 2^32)
// Priority: redirect > increment > hold.
// -----------------------------------------------------------------------------
module pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_inc,
  input  logic              i_redir,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc4
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc4;

  // Natural 32-bit overflow gives the required modulo-2^32 wrap.
  assign w_pc4 = r_pc + PC_STEP;

  // NOTE: clocked state is written with <= so every register in the design
  // samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_redir) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= w_pc4;
    end
  end

  assign o_pc  = r_pc;
  assign o_pc4 = w_pc4;

endmodule : pc_reg

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch stage: drives the ROM address from the PC, captures the
// returned word into a one-entry output register, and hands it to decode
// with a valid/ready handshake. Supports redirect (flush), halt, and an
// optional address bounds check.
//
// Parameters
//   RESET_PC    : byte address of the first fetch after reset
//   IMEM_DEPTH  : instruction memory size in 32-bit words
// Ports
//   clock, reset_n            : clock, asynchronous active-low reset
//   imem_addr  (out, 32)      : ROM byte address (= PC register)
//   imem_data  (in, 32)       : ROM word for imem_addr, same cycle
//   redir_valid/redir_target  : redirect request and byte target
//   halt                      : stop fetching (sticky until reset)
//   id_ready                  : decode accepts if_instr this cycle
//   if_valid/if_instr/if_pc/if_pc4 : registered instruction to decode
//   fetch_count (out, 32)     : number of completed handshakes (wraps)
//   state_o (out, 2)          : current FSM state
// Build option
//   FETCH_BOUNDS_CHECK_EN : when defined, fetching a word index >= IMEM_DEPTH
//                           enters FAULT instead of wrapping in the ROM.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                IMEM_DEPTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              halt,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output logic [31:0]       fetch_count,
  output logic [1:0]        state_o
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(IMEM_DEPTH);

  state_e            r_state;
  logic              r_if_valid;
  logic [WORD_W-1:0] r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_pc4;
  logic [31:0]       r_fetch_count;

  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_target;
  logic              w_in_fetch;
  logic              w_handshake;
  logic              w_free;
  logic              w_take_halt;
  logic              w_take_redir;
  logic              w_out_of_range;
  logic              w_fault;
  logic              w_load;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_in_fetch     = 1'b0;
    w_handshake    = 1'b0;
    w_free         = 1'b0;
    w_take_halt    = 1'b0;
    w_take_redir   = 1'b0;
    w_out_of_range = 1'b0;
    w_fault        = 1'b0;
    w_load         = 1'b0;
    w_target       = align_word(redir_target);

    w_in_fetch  = (r_state == ST_FETCH);
    w_handshake = r_if_valid & id_ready;
    // Output register can take a new word if empty or being drained now.
    w_free      = ~r_if_valid | w_handshake;

    // Halt beats redirect; redirect beats both increment and stall.
    w_take_halt  = w_in_fetch & halt;
    w_take_redir = w_in_fetch & ~halt & redir_valid;

    // Word index compare; only acted on when the bounds check is built in.
    w_out_of_range = BOUNDS_EN & ({2'b00, w_pc[ADDR_W-1:2]} >= DEPTH_W);

    w_fault = w_in_fetch & ~halt & ~redir_valid & w_free & w_out_of_range;
    w_load  = w_in_fetch & ~halt & ~redir_valid & w_free & ~w_out_of_range;
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_inc    (w_load),
    .i_redir  (w_take_redir),
    .i_target (w_target),
    .o_pc     (w_pc),
    .o_pc4    (w_pc4)
  );

  // FSM and registered outputs. Reset abandons any stall or pending flush:
  // all state lives in these registers and the PC, so nothing survives it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc4      <= '0;
      r_fetch_count <= '0;
    end else begin
      if (w_handshake) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          // One startup bubble before the first ROM word is captured.
          r_if_valid <= 1'b0;
          r_state    <= ST_FETCH;
        end

        ST_FETCH: begin
          if (w_take_halt) begin
            r_if_valid <= 1'b0;
            r_state    <= ST_HALTED;
          end else if (w_take_redir) begin
            // Flush: the held instruction (stalled or not) is discarded.
            r_if_valid <= 1'b0;
          end else if (w_fault) begin
            r_if_valid <= 1'b0;
            r_state    <= ST_FAULT;
          end else if (w_load) begin
            r_if_valid <= 1'b1;
            r_if_instr <= imem_data;
            r_if_pc    <= w_pc;
            r_if_pc4   <= w_pc4;
          end
        end

        ST_HALTED: r_if_valid <= 1'b0;
        ST_FAULT:  r_if_valid <= 1'b0;

        default: begin
          r_if_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = w_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc4      = r_if_pc4;
  assign fetch_count = r_fetch_count;
  assign state_o     = r_state;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl (default parameters): a table of
// directed vectors for start-up, stall and redirect, hand-written sequences
// for halt, reset, bounds and PC wrap, then randomized traffic compared
// against a cycle-level reference model kept here.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        halt;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] fetch_count;
  logic [1:0]  state_o;

  logic [31:0] rom [32];

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  fetch_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .halt         (halt),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc4       (if_pc4),
    .fetch_count  (fetch_count),
    .state_o      (state_o)
  );

  // ROM with 5-bit word index: addresses beyond 32 words wrap.
  assign imem_data = rom[imem_addr[6:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (0 idle, 1 fetching, 2 halted, 3 fault).
  int          m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic [31:0] m_pc4;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_ifpc  = 32'h0;
    m_pc4   = 32'h0;
    m_count = 32'h0;
  endtask

  // Effect of one rising edge, from the inputs currently applied.
  task automatic model_edge();
    bit hs;
    hs = m_valid && id_ready;
    if (hs) m_count = m_count + 1;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (halt) begin
        m_state = 2;
        m_valid = 1'b0;
      end else if (redir_valid) begin
        m_pc    = (redir_target / 4) * 4;
        m_valid = 1'b0;
      end else if (!m_valid || hs) begin
        if (BOUNDS && (m_pc / 4) >= 32) begin
          m_state = 3;
          m_valid = 1'b0;
        end else begin
          m_instr = rom[(m_pc / 4) % 32];
          m_ifpc  = m_pc;
          m_pc4   = m_pc + 4;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
        end
      end
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic step();
    if (!reset_n) model_reset();
    else model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    check({tag, ".state"}, {30'd0, state_o}, 32'(m_state));
    check({tag, ".count"}, fetch_count, m_count);
    check({tag, ".if_pc"}, if_pc, m_ifpc);
    check({tag, ".if_pc4"}, if_pc4, m_pc4);
    check({tag, ".instr"}, if_instr, m_instr);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear at once.
  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst.async_valid", {31'd0, if_valid}, 32'd0);
    check("rst.async_count", fetch_count, 32'd0);
    compare_all("rst");
    step();
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0003;

    // Start-up, 3-cycle stall at pc 8, then stall + redirect to 0x13.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'd0, 2'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'd0, 2'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'd1, 2'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 2'd1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'd3, 2'd1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'd4, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 32'd4, 2'd1};
    vecs[10] = '{1'b0, 1'b1, 32'h13, 1'b0, 32'h10, 32'd4, 2'd1};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'd4, 2'd1};
    vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 32'd5, 2'd1};

    reset_n      = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    halt         = 1'b0;
    id_ready     = 1'b0;
    model_reset();
    step();
    step();
    check("reset.state", {30'd0, state_o}, 32'd0);
    check("reset.valid", {31'd0, if_valid}, 32'd0);
    check("reset.imem_addr", imem_addr, 32'h0);
    compare_all("reset");
    reset_n = 1'b1;

    // ---- table-driven vectors -------------------------------------------
    for (int i = 0; i < 13; i++) begin
      id_ready     = vecs[i].ready;
      redir_valid  = vecs[i].redir;
      redir_target = vecs[i].target;
      halt         = 1'b0;
      step();
      check($sformatf("vec%0d.valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d.if_pc", i), if_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.count", i), fetch_count, vecs[i].exp_count);
      check($sformatf("vec%0d.state", i), {30'd0, state_o}, {30'd0, vecs[i].exp_state});
      if (vecs[i].exp_valid) begin
        w = rom[vecs[i].exp_pc[6:2]];
        check($sformatf("vec%0d.instr", i), if_instr, w);
        check($sformatf("vec%0d.if_pc4", i), if_pc4, vecs[i].exp_pc + 32'd4);
      end
      compare_all($sformatf("vec%0d", i));
    end

    // ---- halt with simultaneous redirect; later redirects ignored -------
    id_ready     = 1'b1;
    halt         = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 32'h40;
    step();
    check("halt.state", {30'd0, state_o}, 32'd2);
    check("halt.valid", {31'd0, if_valid}, 32'd0);
    check("halt.pc_frozen", imem_addr, 32'h18);
    compare_all("halt");
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halted.state", {30'd0, state_o}, 32'd2);
      check("halted.pc_frozen", imem_addr, 32'h18);
      compare_all("halted");
    end

    // ---- reset mid-stream: restart at RESET_PC --------------------------
    redir_valid = 1'b0;
    reset_pulse();
    step();
    check("restart.bubble", {31'd0, if_valid}, 32'd0);
    step();
    check("restart.valid", {31'd0, if_valid}, 32'd1);
    check("restart.if_pc", if_pc, 32'h0);
    compare_all("restart");

    // ---- sequential fetch across the end of a 32-word ROM ---------------
    redir_valid  = 1'b1;
    redir_target = 32'h78;
    step();
    redir_valid = 1'b0;
    step();
    check("bounds.if_pc78", if_pc, 32'h78);
    step();
    check("bounds.if_pc7c", if_pc, 32'h7C);
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("bounds.fault_state", {30'd0, state_o}, 32'd3);
    check("bounds.fault_valid", {31'd0, if_valid}, 32'd0);
`else
    w = rom[0];
    check("bounds.wrap_if_pc", if_pc, 32'h80);
    check("bounds.wrap_instr", if_instr, w);
    check("bounds.wrap_valid", {31'd0, if_valid}, 32'd1);
    // PC + 4 wraps modulo 2^32.
    redir_valid  = 1'b1;
    redir_target = 32'hFFFF_FFFE;
    step();
    redir_valid = 1'b0;
    step();
    check("wrap.if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap.if_pc4", if_pc4, 32'h0);
    check("wrap.imem_addr", imem_addr, 32'h0);
`endif
    compare_all("bounds");

    // ---- randomized traffic vs reference model --------------------------
    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      if ((m_state >= 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
        reset_pulse();
      end else begin
        id_ready    = ($urandom_range(0, 3) != 0);
        redir_valid = ($urandom_range(0, 7) == 0);
        halt        = ($urandom_range(0, 199) == 0);
        if (!BOUNDS && $urandom_range(0, 63) == 0) redir_target = $urandom;
        else redir_target = 32'($urandom_range(0, 127));
        step();
        compare_all("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 32: instruction memory size in 32-bit words.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to the instruction ROM, driven directly from the PC register.
REQ-006 SHALL have port imem_data, input, 32 bits: ROM word for imem_addr, valid combinationally in the same cycle.
REQ-007 SHALL have port redir_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redir_target, input, 32 bits: redirect byte address.
REQ-009 SHALL have port halt, input, 1 bit: stop fetching.
REQ-010 SHALL have port id_ready, input, 1 bit: decode stage accepts the instruction.
REQ-011 SHALL have ports if_valid (output, 1 bit), if_instr (output, 32 bits), if_pc (output, 32 bits) and if_pc4 (output, 32 bits): the registered instruction, its address, and that address plus 4.
REQ-012 SHALL have ports fetch_count (output, 32 bits: handshake counter) and state_o (output, 2 bits: current FSM state).

Function
REQ-013 SHALL implement FSM states IDLE=0, FETCH=1, HALTED=2, FAULT=3.
REQ-014 IDLE SHALL hold if_valid=0 and SHALL move to FETCH unconditionally on the next edge: one startup bubble.
REQ-015 A handshake SHALL occur when if_valid=1 and id_ready=1.
REQ-016 In FETCH, when the output register is free (if_valid=0 or handshake), it SHALL load if_instr<=imem_data, if_pc<=pc, if_pc4<=pc+4 and if_valid<=1, and pc SHALL become pc+4.
REQ-017 When if_valid=1 and id_ready=0 (stall), if_instr, if_pc, if_pc4 and pc SHALL be held unchanged.
REQ-018 When redir_valid=1 in FETCH, pc SHALL load {redir_target[31:2],2'b00} and if_valid SHALL clear the next cycle (flush). A stalled instruction SHALL be discarded. The first redirected instruction SHALL appear with latency 2 edges.
REQ-019 Redirect SHALL take priority over the sequential increment and over a stall.
REQ-020 halt=1 in FETCH SHALL move to HALTED, clear if_valid and freeze pc.
REQ-021 halt SHALL take priority over a simultaneous redirect: the redirect is dropped.
REQ-022 HALTED SHALL be left only by reset.
REQ-023 fetch_count SHALL increment by 1 per handshake and wrap from 32'hFFFF_FFFF to 0.
REQ-024 pc+4 SHALL wrap modulo 2^32.

Reset
REQ-025 On reset_n=0 the block SHALL asynchronously set: state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, fetch_count=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL abandon all pending work, with no residual flush or redirect after release.

Configuration
REQ-027 With FETCH_BOUNDS_CHECK_EN defined, a pc word index (pc>>2) >= IMEM_DEPTH in FETCH SHALL move to FAULT with if_valid=0 and no ROM word captured. FAULT SHALL be left only by reset.
REQ-028 Without FETCH_BOUNDS_CHECK_EN, FAULT SHALL be unreachable and addressing beyond IMEM_DEPTH SHALL be left to the ROM's index truncation (wrap).

Structure
REQ-029 Shared package SHALL hold the FSM state encodings, the RESET_PC default and the 32-bit word/address width constants.
REQ-030 A sub-module pc_reg SHALL hold the PC register with its next-PC mux (increment / redirect / hold).

Verification
REQ-031 Reset release with id_ready=1 and ROM words 0..3 SHALL give if_valid=1 from the 2nd edge with if_pc=0,4,8,12 on successive cycles and fetch_count=4 after four handshakes.
REQ-032 Holding id_ready=0 for 3 cycles at if_pc=8 SHALL keep if_instr and if_pc stable with no fetch_count change; after release, if_pc SHALL be 12 next.
REQ-033 redir_valid=1 with redir_target=32'h0000_0013 during a stall SHALL give one bubble, then if_pc=32'h10 with the stalled instruction never handshaken.
REQ-034 halt=1 and redir_valid=1 in the same cycle SHALL give state_o=2, if_valid=0 and pc frozen; a later redirect SHALL be ignored.
REQ-035 With FETCH_BOUNDS_CHECK_EN and IMEM_DEPTH=32, sequential fetch to address 32'h80 SHALL give state_o=3 and if_valid=0. Without the macro, the same stimulus SHALL fetch ROM word 0 at if_pc=32'h80.
REQ-036 reset_n pulsed low mid-stream SHALL clear outputs immediately, and fetch SHALL restart at RESET_PC.
